// File: rtl/senior_priority_arbiter.sv
// Senior-first resource arbiter with grant hold, hold timeout and fairness mask.
// Ports: clk, rst (sync, active-high), req[N], gnt[N] one-hot, gnt_idx, busy, timeout.

// Picks the highest-index set bit of vec as a one-hot plus its binary index.
module screening_by_senior #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  sel,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    sel = '0;
    idx = '0;
    any = |vec;
    // Ascending scan: the last set bit seen is the most senior.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end
endmodule

module senior_priority_arbiter #(
  parameter int REQ_COUNT  = 8,
  parameter int HOLD_LIMIT = 16,
  parameter int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_COUNT-1:0] req,
  output logic [REQ_COUNT-1:0] gnt,
  output logic [IW-1:0]        gnt_idx,
  output logic                 busy,
  output logic                 timeout
);
  localparam int CW =
    (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM =
    CW'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);
  localparam logic HAS_LIM = (HOLD_LIMIT > 0);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state, state_nx;

  logic [REQ_COUNT-1:0] mask, mask_nx;
  logic [REQ_COUNT-1:0] gnt_nx;
  logic [IW-1:0]        idx_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 timeout_nx;

  logic [REQ_COUNT-1:0] elig;
  logic [REQ_COUNT-1:0] elig_sel, req_sel;
  logic [IW-1:0]        elig_idx, req_idx;
  logic                 elig_any, req_any;
  logic                 owner_req;
  logic                 limit_hit;

  assign elig = req & mask;

  screening_by_senior #(.W(REQ_COUNT), .IW(IW)) u_elig (
    .vec (elig),
    .sel (elig_sel),
    .idx (elig_idx),
    .any (elig_any)
  );

  screening_by_senior #(.W(REQ_COUNT), .IW(IW)) u_req (
    .vec (req),
    .sel (req_sel),
    .idx (req_idx),
    .any (req_any)
  );

  assign owner_req = |(req & gnt);
  assign limit_hit = HAS_LIM && (cnt == LIM);
  assign busy      = (state == GRANT);

  always_comb begin
    state_nx   = state;
    mask_nx    = mask;
    gnt_nx     = gnt;
    idx_nx     = gnt_idx;
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (elig_any) begin
          gnt_nx   = elig_sel;
          idx_nx   = elig_idx;
          cnt_nx   = '0;
          state_nx = GRANT;
        end else if (req_any) begin
          // Every pending requester is masked: start a new round.
          mask_nx  = '1;
          gnt_nx   = req_sel;
          idx_nx   = req_idx;
          cnt_nx   = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || limit_hit) begin
          mask_nx    = mask & ~gnt;
          gnt_nx     = '0;
          idx_nx     = '0;
          cnt_nx     = '0;
          state_nx   = IDLE;
          // A voluntary drop wins over a coincident limit.
          timeout_nx = owner_req;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask    <= '1;
      gnt     <= '0;
      gnt_idx <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      mask    <= mask_nx;
      gnt     <= gnt_nx;
      gnt_idx <= idx_nx;
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_senior_priority_arbiter.sv
// Bench for senior_priority_arbiter: directed scenarios plus random traffic
// checked every cycle against an owner/mask reference model.
module tb_senior_priority_arbiter;
  localparam int N  = 8;
  localparam int HL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         busy;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  int           m_owner;
  int           m_held;
  logic [N-1:0] m_mask;
  logic         m_to;

  always #5 clk = ~clk;

  senior_priority_arbiter #(
    .REQ_COUNT  (N),
    .HOLD_LIMIT (HL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int top_bit(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model(input logic [N-1:0] r, input logic rr);
    logic [N-1:0] e;
    m_to = 1'b0;
    if (rr) begin
      m_owner = -1;
      m_held  = 0;
      m_mask  = '1;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        e = r & m_mask;
        if (e == 0) begin
          m_mask = '1;
          e      = r;
        end
        m_owner = top_bit(e);
        m_held  = 1;
      end
    end else if (!r[m_owner]) begin
      m_mask[m_owner] = 1'b0;
      m_owner = -1;
    end else if (m_held == HL) begin
      m_mask[m_owner] = 1'b0;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rr);
    logic [N-1:0] eg;
    @(negedge clk);
    req = r;
    rst = rr;
    @(posedge clk);
    model(r, rr);
    #1;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_idx", 32'(gnt_idx),
        32'((m_owner < 0) ? 0 : m_owner));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot", 32'($countones(gnt) <= 1), 32'(1));
  endtask

  int           hold_len;
  logic [N-1:0] rv;

  initial begin
    rst = 1'b1;
    req = '0;
    m_owner = -1;
    m_held  = 0;
    m_mask  = '1;
    m_to    = 1'b0;

    step('0, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'(0));
    repeat (5) step('0, 1'b0);
    chk("idle_busy", 32'(busy), 32'(0));

    step(8'b0010_0101, 1'b0);
    chk("senior_gnt", 32'(gnt), 32'h20);
    chk("senior_idx", 32'(gnt_idx), 32'd5);
    step(8'b0000_0101, 1'b0);
    step(8'b0000_0101, 1'b0);
    chk("after_rel", 32'(gnt), 32'h04);

    step('0, 1'b1);
    step(8'b1000_0001, 1'b0);
    chk("fair_7", 32'(gnt), 32'h80);
    step(8'b1000_0001, 1'b0);
    step(8'b0000_0001, 1'b0);
    chk("fair_gap", 32'(gnt), 32'h00);
    step(8'b1000_0001, 1'b0);
    chk("fair_0", 32'(gnt), 32'h01);
    step(8'b1000_0000, 1'b0);
    step(8'b1000_0000, 1'b0);
    chk("fair_reload", 32'(gnt), 32'h80);

    step('0, 1'b1);
    hold_len = 0;
    step(8'b0000_1010, 1'b0);
    while (gnt == 8'h08 && hold_len < 10) begin
      hold_len++;
      step(8'b0000_1010, 1'b0);
    end
    chk("to_len", 32'(hold_len), 32'd4);
    chk("to_pulse", 32'(timeout), 32'd1);
    step(8'b0000_1010, 1'b0);
    chk("to_clear", 32'(timeout), 32'd0);
    chk("to_junior", 32'(gnt), 32'h02);

    step('0, 1'b1);
    step(8'b0001_0000, 1'b0);
    repeat (2) step(8'b0001_0000, 1'b0);
    step(8'b0001_0000, 1'b0);
    step(8'b0000_0000, 1'b0);
    chk("race_gnt", 32'(gnt), 32'd0);
    chk("race_to", 32'(timeout), 32'd0);

    step(8'b0100_0000, 1'b0);
    chk("mid_gnt", 32'(gnt), 32'h40);
    step(8'b0100_0000, 1'b1);
    chk("mid_rst", 32'({gnt, gnt_idx, busy, timeout}), 32'd0);
    step(8'b0100_0000, 1'b0);
    chk("resume", 32'(gnt), 32'h40);

    rv = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
      step(rv, ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
